// File: rtl/counter_seq_ctrl.sv
// Sequencer for an up-counter: clear, count to a latched terminal value, repeat reps+1 periods, pulse done.
// Optional CNT_SEQ_PAUSE_EN adds a pause input that freezes RUN.
module counter_seq_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned REP_W = 3
) (
  input  logic             Clk,
  input  logic             ClrN,
  input  logic             start,
  input  logic [WIDTH-1:0] term,
  input  logic [REP_W-1:0] reps,
  input  logic             abort,
`ifdef CNT_SEQ_PAUSE_EN
  input  logic             pause,
`endif
  input  logic [WIDTH-1:0] cnt_q,
  output logic             cnt_en,
  output logic             cnt_clr_n,
  output logic             busy,
  output logic             done,
  output logic             period_tick,
  output logic [REP_W-1:0] periods_left
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] term_r, term_nxt;
  logic [REP_W-1:0] left_nxt;
  logic             hit;
  logic             hold;

`ifdef CNT_SEQ_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  assign hit = (cnt_q == term_r);

  always_ff @(posedge Clk or negedge ClrN) begin
    if (!ClrN) begin
      state        <= IDLE;
      term_r       <= '0;
      periods_left <= '0;
    end else begin
      state        <= state_nxt;
      term_r       <= term_nxt;
      periods_left <= left_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    term_nxt    = term_r;
    left_nxt    = periods_left;
    cnt_en      = 1'b0;
    cnt_clr_n   = 1'b1;
    busy        = 1'b0;
    done        = 1'b0;
    period_tick = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          term_nxt  = term;
          left_nxt  = reps;
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        cnt_clr_n = 1'b0;
        busy      = 1'b1;
        state_nxt = abort ? IDLE : RUN;
      end
      RUN: begin
        busy   = 1'b1;
        cnt_en = !hit && !hold;
        // abort suppresses the tick pulse as well as the transition it would cause
        if (abort) begin
          state_nxt = IDLE;
        end else if (hit && !hold) begin
          period_tick = 1'b1;
          if (periods_left == '0) begin
            state_nxt = DONE;
          end else begin
            left_nxt  = periods_left - REP_W'(1);
            state_nxt = CLEAR;
          end
        end
      end
      DONE: begin
        done      = !abort;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl with a behavioural counter attached to cnt_en/cnt_clr_n.
module tb_counter_seq_ctrl;

  logic       Clk = 1'b0;
  logic       ClrN = 1'b0;
  logic       start = 1'b0;
  logic [3:0] term = '0;
  logic [2:0] reps = '0;
  logic       abort = 1'b0;
  logic [3:0] cnt_q;
  logic       cnt_en, cnt_clr_n, busy, done, period_tick;
  logic [2:0] periods_left;
`ifdef CNT_SEQ_PAUSE_EN
  logic       pause = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;

  counter_seq_ctrl #(.WIDTH(4), .REP_W(3)) dut (
    .Clk(Clk), .ClrN(ClrN), .start(start), .term(term), .reps(reps), .abort(abort),
`ifdef CNT_SEQ_PAUSE_EN
    .pause(pause),
`endif
    .cnt_q(cnt_q), .cnt_en(cnt_en), .cnt_clr_n(cnt_clr_n), .busy(busy), .done(done),
    .period_tick(period_tick), .periods_left(periods_left)
  );

  always #5 Clk = ~Clk;

  // Counter model: synchronous clear wins, otherwise increment mod 16
  always @(posedge Clk or negedge ClrN) begin
    if (!ClrN)           cnt_q <= '0;
    else if (!cnt_clr_n) cnt_q <= '0;
    else if (cnt_en)     cnt_q <= cnt_q + 4'd1;
  end

  typedef struct {
    logic       start;
    logic       abort;
    logic [3:0] term;
    logic [2:0] reps;
    logic [3:0] q;
    logic       en, clrn, busy, done, tick;
    logic [2:0] pl;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic s, logic a, logic [3:0] t, logic [2:0] r, logic [3:0] q,
                              logic en, logic clrn, logic b, logic d, logic tk, logic [2:0] pl);
    vec_t v;
    v.start = s; v.abort = a; v.term = t; v.reps = r; v.q = q;
    v.en = en; v.clrn = clrn; v.busy = b; v.done = d; v.tick = tk; v.pl = pl;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] outs();
    return {cnt_q, cnt_en, cnt_clr_n, busy, done, period_tick, periods_left};
  endfunction

  // sel 0: RUN-phase cnt_q equals v; sel 1: period_tick high
  task automatic wait_for(input int sel, input logic [3:0] v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk); #1;
      if (sel == 0 && busy && cnt_clr_n && cnt_q == v) begin ok = 1'b1; return; end
      if (sel == 1 && period_tick) begin ok = 1'b1; return; end
    end
  endtask

  initial begin
    bit ok;
    int tick_c[$];
    int tick_pl[$];
    int done_c;
    int seen;

    // term=5 reps=0, with term/reps changed after accept and start retried while busy/DONE
    vecs.push_back(mk(1,0,5,0, 0,0,1,0,0,0,0));
    vecs.push_back(mk(0,0,9,7, 0,0,0,1,0,0,0));
    vecs.push_back(mk(0,0,9,7, 0,1,1,1,0,0,0));
    vecs.push_back(mk(0,0,9,7, 1,1,1,1,0,0,0));
    vecs.push_back(mk(1,0,9,7, 2,1,1,1,0,0,0));
    vecs.push_back(mk(0,0,9,7, 3,1,1,1,0,0,0));
    vecs.push_back(mk(0,0,9,7, 4,1,1,1,0,0,0));
    vecs.push_back(mk(0,0,9,7, 5,0,1,1,0,1,0));
    vecs.push_back(mk(1,0,9,7, 5,0,1,0,1,0,0));
    vecs.push_back(mk(0,0,9,7, 5,0,1,0,0,0,0));
    // term=0: no cnt_en, tick in cycle 2, done in cycle 3
    vecs.push_back(mk(1,0,0,0, 5,0,1,0,0,0,0));
    vecs.push_back(mk(0,0,4,3, 5,0,0,1,0,0,0));
    vecs.push_back(mk(0,0,4,3, 0,0,1,1,0,1,0));
    vecs.push_back(mk(0,0,4,3, 0,0,1,0,1,0,0));
    vecs.push_back(mk(0,0,4,3, 0,0,1,0,0,0,0));

    // Reset held 45 ns
    #20;
    chk("reset_during", {cnt_en, cnt_clr_n, busy, done, period_tick, periods_left}, {5'b01000, 3'd0});
    #25 ClrN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk); #1;
      chk("idle_after_reset", outs(), {4'd0, 5'b01000, 3'd0});
    end

    foreach (vecs[i]) begin
      @(negedge Clk);
      start = vecs[i].start; abort = vecs[i].abort; term = vecs[i].term; reps = vecs[i].reps;
      #1;
      chk($sformatf("vec%0d", i), outs(),
          {vecs[i].q, vecs[i].en, vecs[i].clrn, vecs[i].busy, vecs[i].done, vecs[i].tick, vecs[i].pl});
    end

    // term=3 reps=2: ticks at 5/10/15 with periods_left 2/1/0, done at 16
    @(negedge Clk); start = 1; term = 3; reps = 2;
    @(negedge Clk); start = 0;
    done_c = -1;
    for (int c = 1; c <= 20; c++) begin
      #1;
      if (period_tick) begin tick_c.push_back(c); tick_pl.push_back(int'(periods_left)); end
      if (done && done_c < 0) done_c = c;
      if (c == 16) chk("rep_busy_low_at_done", busy, 0);
      @(negedge Clk);
    end
    chk("rep_tick_count", tick_c.size(), 3);
    if (tick_c.size() == 3) begin
      chk("rep_tick0_cycle", tick_c[0], 5);
      chk("rep_tick1_cycle", tick_c[1], 10);
      chk("rep_tick2_cycle", tick_c[2], 15);
      chk("rep_tick0_pl", tick_pl[0], 2);
      chk("rep_tick1_pl", tick_pl[1], 1);
      chk("rep_tick2_pl", tick_pl[2], 0);
    end
    chk("rep_done_cycle", done_c, 16);

    // abort in RUN at cnt_q=2, start on the abort cycle ignored
    start = 1; term = 6; reps = 1;
    @(negedge Clk); start = 0;
    wait_for(0, 4'd2, ok);
    chk("abort_run_reached", ok, 1);
    abort = 1; start = 1; #1;
    chk("abort_run_cycle", {busy, period_tick, done}, 3'b100);
    @(negedge Clk); abort = 0; start = 0; #1;
    chk("abort_run_idle", {busy, periods_left}, {1'b0, 3'd1});
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk); #1;
      if (done || busy) seen++;
    end
    chk("abort_run_quiet", seen, 0);

    // abort on the tick cycle: no tick, periods_left held
    start = 1; term = 2; reps = 1;
    @(negedge Clk); start = 0;
    wait_for(1, 4'd0, ok);
    chk("abort_tick_reached", ok, 1);
    chk("abort_tick_pl_before", periods_left, 1);
    abort = 1; #1;
    chk("abort_tick_suppressed", {period_tick, busy}, 2'b01);
    @(negedge Clk); abort = 0; #1;
    chk("abort_tick_idle", {busy, periods_left}, {1'b0, 3'd1});
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk); #1;
      if (done || busy) seen++;
    end
    chk("abort_tick_quiet", seen, 0);

    // ClrN asserted mid-RUN
    start = 1; term = 7; reps = 3;
    @(negedge Clk); start = 0;
    wait_for(0, 4'd3, ok);
    chk("clrn_run_reached", ok, 1);
    chk("clrn_pl_before", periods_left, 3);
    ClrN = 0; #1;
    chk("clrn_immediate", {cnt_en, cnt_clr_n, busy, done, period_tick, periods_left}, {5'b01000, 3'd0});
    @(negedge Clk); ClrN = 1;
    @(negedge Clk); #1;
    chk("clrn_release_idle", {busy, cnt_clr_n, done}, 3'b010);

`ifdef CNT_SEQ_PAUSE_EN
    // pause 3 cycles at cnt_q=2: done moves from cycle 8 to 11
    @(negedge Clk); start = 1; term = 5; reps = 0;
    @(negedge Clk); start = 0;
    done_c = -1;
    for (int c = 1; c <= 16; c++) begin
      pause = (c >= 4 && c <= 6);
      #1;
      if (pause) chk("pause_hold", {cnt_q, cnt_en, period_tick}, {4'd2, 2'b00});
      if (done && done_c < 0) done_c = c;
      @(negedge Clk);
    end
    pause = 0;
    chk("pause_done_cycle", done_c, 11);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
